// File: rtl/mult_seq.sv
// Sequential radix-2 shift-add multiplier, signed/unsigned; fixed WIDTH+2 cycle latency, START ignored while busy.
// Define MULT_SEQ_EARLY_EXIT_EN to end CALC once the remaining multiplier bits are all zero.
module mult_seq #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             SIGNED_OP,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_FIX,
      ST_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               neg_q, neg_d;
   logic [CW-1:0]      cnt_q, cnt_d;

   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] step;
   logic [2*WIDTH-1:0] prod;

`ifdef MULT_SEQ_EARLY_EXIT_EN
   logic [CW-1:0]      rem;
   logic [WIDTH-1:0]   mask;
`endif

   always_comb begin
      a_neg = SIGNED_OP & A[WIDTH-1];
      b_neg = SIGNED_OP & B[WIDTH-1];
      a_mag = a_neg ? -A : A;
      b_mag = b_neg ? -B : B;

      // Upper half plus multiplicand keeps its carry; the whole word then shifts right by one.
      sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
      step = {sum, acc_q[WIDTH-1:1]};
      prod = neg_q ? -acc_q : acc_q;

`ifdef MULT_SEQ_EARLY_EXIT_EN
      rem  = CW'(WIDTH - 1) - cnt_q;
      mask = {WIDTH{1'b1}} >> (cnt_q + CW'(1));
`endif

      state_d = state_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      neg_d   = neg_q;
      cnt_d   = cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (START) begin
               mcand_d = a_mag;
               acc_d   = {{WIDTH{1'b0}}, b_mag};
               neg_d   = a_neg ^ b_neg;
               cnt_d   = '0;
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            acc_d = step;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = ST_FIX;
            end
`ifdef MULT_SEQ_EARLY_EXIT_EN
            // Remaining multiplier bits are zero: the skipped steps would only shift.
            if ((step[WIDTH-1:0] & mask) == '0) begin
               acc_d   = step >> rem;
               state_d = ST_FIX;
            end
`endif
         end
         ST_FIX: begin
            hi_d    = prod[2*WIDTH-1:WIDTH];
            lo_d    = prod[WIDTH-1:0];
            state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         mcand_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         neg_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         neg_q   <= neg_d;
         cnt_q   <= cnt_d;
      end
   end

   assign BUSY = (state_q != ST_IDLE);
   assign DONE = (state_q == ST_DONE);
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq: cycle-level behavioural model plus hand-computed product checks.
module tb_mult_seq;
   localparam int W = 32;

   logic         CLK, RST, START, SIGNED_OP;
   logic [W-1:0] A, B, HI, LO;
   logic         BUSY, DONE;

   int   n_vec  = 0;
   int   n_err  = 0;
   int   n_done = 0;
   logic chk_en = 1'b0;

   mult_seq #(.WIDTH(W)) dut (
      .CLK(CLK), .RST(RST), .START(START), .SIGNED_OP(SIGNED_OP),
      .A(A), .B(B), .BUSY(BUSY), .DONE(DONE), .HI(HI), .LO(LO)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [63:0] ref_prod(input logic s, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      return {32'd0, a} * {32'd0, b};
   endfunction

   function automatic int ref_lat(input logic s, input logic [31:0] b);
`ifdef MULT_SEQ_EARLY_EXIT_EN
      logic [31:0] m;
      int steps;
      m = (s && b[31]) ? -b : b;
      steps = 1;
      for (int i = 0; i < 32; i++) if (m[i]) steps = i + 1;
      return steps + 2;
`else
      return W + 2;
`endif
   endfunction

   // Model: m_phase counts down the cycles left until the DONE cycle (value 1); 0 = idle.
   int          m_phase = 0;
   logic [63:0] m_pend  = '0;
   logic [63:0] m_hl    = '0;

   always @(posedge CLK) begin
      if (!RST) begin
         m_phase = 0;
         m_hl    = '0;
      end else if (m_phase == 0) begin
         if (START) begin
            m_phase = ref_lat(SIGNED_OP, B);
            m_pend  = ref_prod(SIGNED_OP, A, B);
         end
      end else begin
         m_phase--;
         if (m_phase == 1) m_hl = m_pend;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge CLK) begin
      if (DONE) n_done++;
      if (chk_en) begin
         if (!RST) begin
            chk("busy_in_reset", 64'(BUSY), 64'(0));
            chk("done_in_reset", 64'(DONE), 64'(0));
            chk("hilo_in_reset", {HI, LO}, 64'(0));
         end else begin
            chk("busy", 64'(BUSY), 64'(m_phase != 0));
            chk("done", 64'(DONE), 64'(m_phase == 1));
            chk("hi", 64'(HI), 64'(m_hl[63:32]));
            chk("lo", 64'(LO), 64'(m_hl[31:0]));
         end
      end
   end

   // Call at posedge+1 with the DUT idle; returns at posedge+1 after the DONE cycle.
   task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input int elat);
      int   lat;
      logic seen;
      START = 1'b1; SIGNED_OP = s; A = a; B = b;
      @(posedge CLK); #1;
      START = 1'b0; A = $urandom; B = $urandom; SIGNED_OP = 1'($urandom);
      lat = 0; seen = 1'b0;
      while (!seen && lat < 200) begin
         @(negedge CLK);
         lat++;
         if (DONE) seen = 1'b1;
      end
      chk("latency", 64'(lat), 64'(elat));
      chk("hi_literal", 64'(HI), 64'(ehi));
      chk("lo_literal", 64'(LO), 64'(elo));
      @(posedge CLK); #1;
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic        rs;
      logic [63:0] p;
      RST = 1'b1; START = 1'b0; SIGNED_OP = 1'b0; A = '0; B = '0;
      #2 RST = 1'b0;
      #1;
      chk("reset_busy", 64'(BUSY), 64'(0));
      chk("reset_done", 64'(DONE), 64'(0));
      chk("reset_hi", 64'(HI), 64'(0));
      chk("reset_lo", 64'(LO), 64'(0));
      repeat (2) @(posedge CLK);
      #1 RST = 1'b1;
      chk_en = 1'b1;

      run_op(1'b1, 32'd5, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFDD, ref_lat(1'b1, 32'hFFFF_FFF9));
      run_op(1'b1, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ref_lat(1'b1, 32'hFFFF_FFFF));
      run_op(1'b1, 32'd8, 32'd7, 32'h0000_0000, 32'h0000_0038, ref_lat(1'b1, 32'd7));
      run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, ref_lat(1'b0, 32'hFFFF_FFFF));
      run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, ref_lat(1'b1, 32'h8000_0000));
`ifdef MULT_SEQ_EARLY_EXIT_EN
      run_op(1'b0, 32'd9, 32'd0, 32'd0, 32'd0, 3);
      run_op(1'b0, 32'd9, 32'd2, 32'd0, 32'h12, 4);
`else
      run_op(1'b0, 32'd9, 32'd0, 32'd0, 32'd0, 34);
      run_op(1'b0, 32'd9, 32'd2, 32'd0, 32'h12, 34);
`endif

      for (int i = 0; i < 16; i++) begin
         rs = 1'($urandom);
         case ($urandom_range(5, 0))
            0: ra = 32'h8000_0000;
            1: ra = 32'h7FFF_FFFF;
            2: ra = 32'hFFFF_FFFF;
            default: ra = $urandom;
         endcase
         case ($urandom_range(5, 0))
            0: rb = 32'd0;
            1: rb = 32'd1;
            2: rb = 32'h8000_0000;
            default: rb = $urandom;
         endcase
         p = ref_prod(rs, ra, rb);
         run_op(rs, ra, rb, p[63:32], p[31:0], ref_lat(rs, rb));
      end

      // Back-to-back START with operands changing every cycle.
      n_done = 0;
      for (int i = 0; i < 100; i++) begin
         START = 1'b1; SIGNED_OP = 1'($urandom); A = $urandom; B = $urandom;
         @(posedge CLK); #1;
      end
      START = 1'b0;
      repeat (45) @(posedge CLK);
      #1;
`ifndef MULT_SEQ_EARLY_EXIT_EN
      chk("b2b_done_count", 64'(n_done), 64'(3));
`endif

      // Reset in the middle of CALC, with START held during reset.
      START = 1'b1; SIGNED_OP = 1'b0; A = 32'd123; B = 32'd456;
      @(posedge CLK); #1;
      START = 1'b0;
      repeat (10) @(posedge CLK);
      #1;
      RST = 1'b0; START = 1'b1;
      #1;
      chk("midop_rst_busy", 64'(BUSY), 64'(0));
      chk("midop_rst_done", 64'(DONE), 64'(0));
      chk("midop_rst_hi", 64'(HI), 64'(0));
      chk("midop_rst_lo", 64'(LO), 64'(0));
      @(posedge CLK);
      @(posedge CLK); #1;
      START = 1'b0; RST = 1'b1;
      @(posedge CLK); #1;
      chk("idle_after_rst", 64'(BUSY), 64'(0));
      run_op(1'b0, 32'd3, 32'd4, 32'd0, 32'h0000_000C, ref_lat(1'b0, 32'd4));

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
